// File: rtl/eva_intr_agg_if.sv
// eva_intr_agg_if -- event output channel of the interrupt aggregator.
//
// Carries the head of the event FIFO from the aggregator (master) to the
// consumer (slave) with a valid/ready handshake.
//   evt_valid   master->slave  head entry present
//   evt_ready   slave->master  consumer accepts the head entry this cycle
//   evt_vec     master->slave  channel vector of the head entry
//   evt_tstamp  master->slave  detection tick of the head entry (0 when unused)
interface eva_intr_agg_if #(
   parameter int NUM_INTR = 32
);
   logic                evt_valid;
   logic                evt_ready;
   logic [NUM_INTR-1:0] evt_vec;
   logic [63:0]         evt_tstamp;

   modport master (
      output evt_valid,
      output evt_vec,
      output evt_tstamp,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_vec,
      input  evt_tstamp,
      output evt_ready
   );
endinterface

// File: rtl/eva_intr_agg.sv
// eva_intr_agg -- interrupt event aggregator.
//
// Detects rising edges (edge mode) or asserted levels (level mode) on up to
// 64 interrupt lines and queues them as channel vectors in a small FIFO.
// When the FIFO is full, detections coalesce into a pending vector; a
// detection that hits an already-pending bit is counted as lost.
//
// Parameters:
//   NUM_INTR    number of interrupt channels, 1..64
//   FIFO_DEPTH  event FIFO entries, power of two, 2..64
//
// Ports:
//   aclk        clock, rising edge
//   arest_n     asynchronous active-low reset
//   interrupt   raw interrupt lines, synchronous to aclk
//   cfg_level   per-channel mode: 1 = level, 0 = rising edge
//   cfg_mask    per-channel mask: 1 = new detections discarded
//   evt         event output channel (valid/ready, vector, timestamp)
//   fifo_cnt    occupied FIFO entries
//   ovf_cnt     lost-event counter, saturating
//   ovf_clr     single-cycle pulse, clears ovf_cnt (wins over increment)
//
// Build option:
//   EVA_INTR_TSTAMP_EN  when defined, a free-running 64-bit tick is captured
//                       per entry at push and presented on evt_tstamp;
//                       otherwise evt_tstamp is tied to 0.
module eva_intr_agg #(
   parameter int NUM_INTR   = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        aclk,
   input  logic                        arest_n,
   input  logic [NUM_INTR-1:0]         interrupt,
   input  logic [NUM_INTR-1:0]         cfg_level,
   input  logic [NUM_INTR-1:0]         cfg_mask,
   eva_intr_agg_if.master              evt,
   output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
   output logic [15:0]                 ovf_cnt,
   input  logic                        ovf_clr
);

   localparam int           AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]  DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic [NUM_INTR-1:0] intr_ff;
   logic [NUM_INTR-1:0] pend;
   logic [NUM_INTR-1:0] inflight;
   logic [NUM_INTR-1:0] edge_det;
   logic [NUM_INTR-1:0] level_det;
   logic [NUM_INTR-1:0] new_det;
   logic [NUM_INTR-1:0] cand;
   logic [NUM_INTR-1:0] head_vec;
   logic [NUM_INTR-1:0] pop_clr;
   logic [NUM_INTR-1:0] push_set;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [NUM_INTR-1:0] vec_mem [FIFO_DEPTH];
   logic                fifo_full;
   logic                push;
   logic                pop;
   logic                loss;

   // Level channels are suppressed while their previous event is queued
   // (inflight) or waiting to be queued (pend), so a held level yields one
   // entry per consumer pop rather than one per cycle.
   assign edge_det  = interrupt & ~intr_ff & ~cfg_level;
   assign level_det = interrupt & cfg_level & ~inflight & ~pend;
   assign new_det   = (edge_det | level_det) & ~cfg_mask;
   assign cand      = pend | new_det;

   assign head_vec      = vec_mem[rd_ptr];
   assign evt.evt_valid = (fifo_cnt != '0);
   assign evt.evt_vec   = evt.evt_valid ? head_vec : '0;

   assign pop       = evt.evt_valid & evt.evt_ready;
   assign fifo_full = (fifo_cnt == DEPTH_C);
   // A pop in the same cycle frees the slot, so a full FIFO can still push.
   assign push      = (|cand) & (~fifo_full | pop);
   // Only edge detections can collide with pend; level_det already masks it.
   assign loss      = |(new_det & pend);

   // Inflight clear uses the current-cycle state, so a level input still high
   // during the popping cycle is re-detected only on the following cycle.
   assign pop_clr  = pop  ? head_vec : '0;
   assign push_set = push ? (cand & cfg_level) : '0;

   always_ff @(posedge aclk or negedge arest_n) begin
      if (!arest_n) begin
         intr_ff  <= '0;
         pend     <= '0;
         inflight <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf_cnt  <= '0;
      end else begin
         intr_ff  <= interrupt;
         pend     <= push ? '0 : cand;
         inflight <= (inflight & ~pop_clr) | push_set;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (ovf_clr)
            ovf_cnt <= '0;
         else if (loss && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'd1;
      end
   end

   // Storage is not reset; the outputs are gated by evt_valid instead.
   always_ff @(posedge aclk) begin
      if (push) vec_mem[wr_ptr] <= cand;
   end

`ifdef EVA_INTR_TSTAMP_EN
   logic [63:0] tick_q;
   logic [63:0] ts_mem [FIFO_DEPTH];

   always_ff @(posedge aclk or negedge arest_n) begin
      if (!arest_n) tick_q <= '0;
      else          tick_q <= tick_q + 64'd1;
   end

   // A coalesced entry carries the tick of the cycle it is finally pushed.
   always_ff @(posedge aclk) begin
      if (push) ts_mem[wr_ptr] <= tick_q;
   end

   assign evt.evt_tstamp = evt.evt_valid ? ts_mem[rd_ptr] : '0;
`else
   assign evt.evt_tstamp = '0;
`endif

endmodule

// File: tb/tb_eva_intr_agg.sv
module tb_eva_intr_agg;

   logic        aclk;
   logic        arest_n;
   logic [31:0] interrupt;
   logic [31:0] cfg_level;
   logic [31:0] cfg_mask;
   logic [3:0]  fifo_cnt;
   logic [15:0] ovf_cnt;
   logic        ovf_clr;

   int n_tests;
   int n_fail;

   logic [31:0] drain_exp [8];

   eva_intr_agg_if #(.NUM_INTR(32)) evt_if ();

   eva_intr_agg #(.NUM_INTR(32), .FIFO_DEPTH(8)) dut (
      .aclk      (aclk),
      .arest_n   (arest_n),
      .interrupt (interrupt),
      .cfg_level (cfg_level),
      .cfg_mask  (cfg_mask),
      .evt       (evt_if),
      .fifo_cnt  (fifo_cnt),
      .ovf_cnt   (ovf_cnt),
      .ovf_clr   (ovf_clr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      arest_n   = 1'b0;
      interrupt = '0;
      cfg_level = '0;
      cfg_mask  = '0;
      ovf_clr   = 1'b0;
      evt_if.evt_ready = 1'b0;
      drain_exp = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80, 32'h700};

      // reset state
      #1;
      chk("rst_valid",  64'(evt_if.evt_valid),  64'd0);
      chk("rst_vec",    64'(evt_if.evt_vec),    64'd0);
      chk("rst_tstamp", evt_if.evt_tstamp,      64'd0);
      chk("rst_cnt",    64'(fifo_cnt),          64'd0);
      chk("rst_ovf",    64'(ovf_cnt),           64'd0);
      step(2);
      arest_n = 1'b1;
      step(1);

      // edge mode: one event, one cycle latency, held high gives nothing more
      interrupt[3]     = 1'b1;
      evt_if.evt_ready = 1'b1;
      chk("edge_pre_valid", 64'(evt_if.evt_valid), 64'd0);
      step(1);
      chk("edge_valid", 64'(evt_if.evt_valid), 64'd1);
      chk("edge_vec",   64'(evt_if.evt_vec),   64'h8);
      chk("edge_cnt",   64'(fifo_cnt),         64'd1);
      step(1);
      chk("edge_pop_valid", 64'(evt_if.evt_valid), 64'd0);
      step(5);
      chk("edge_hold_cnt", 64'(fifo_cnt), 64'd0);
      interrupt = '0;
      step(1);

      // level mode: one entry while unconsumed, re-detect one cycle after pop
      evt_if.evt_ready = 1'b0;
      cfg_level        = 32'h20;
      interrupt        = 32'h20;
      step(20);
      chk("lvl_cnt", 64'(fifo_cnt),       64'd1);
      chk("lvl_vec", 64'(evt_if.evt_vec), 64'h20);
      evt_if.evt_ready = 1'b1;
      step(1);
      chk("lvl_pop_cnt", 64'(fifo_cnt), 64'd0);
      evt_if.evt_ready = 1'b0;
      step(1);
      chk("lvl_re_cnt", 64'(fifo_cnt),       64'd1);
      chk("lvl_re_vec", 64'(evt_if.evt_vec), 64'h20);
      interrupt        = '0;
      cfg_level        = '0;
      evt_if.evt_ready = 1'b1;
      step(1);
      evt_if.evt_ready = 1'b0;
      step(1);
      chk("lvl_clean_cnt", 64'(fifo_cnt), 64'd0);

      // mask: masked pulse dropped; unmasking while high does not re-arm
      cfg_mask  = 32'h80;
      interrupt = 32'h80;
      step(1);
      interrupt = '0;
      step(2);
      chk("mask_pulse_cnt", 64'(fifo_cnt), 64'd0);
      interrupt = 32'h80;
      step(2);
      cfg_mask = '0;
      step(3);
      chk("mask_unmask_cnt", 64'(fifo_cnt), 64'd0);
      interrupt = '0;
      step(1);

      // overflow: 10 distinct edges into an 8-deep FIFO, then a repeat of ch8
      for (int i = 0; i < 10; i++) begin
         interrupt = 32'(1) << i;
         step(1);
      end
      chk("ovf_full_cnt", 64'(fifo_cnt), 64'd8);
      chk("ovf_none",     64'(ovf_cnt),  64'd0);
      interrupt = 32'h100;
      step(1);
      chk("ovf_one",      64'(ovf_cnt),  64'd1);
      chk("ovf_hold_cnt", 64'(fifo_cnt), 64'd8);

      // full FIFO: pop and push in the same cycle
      evt_if.evt_ready = 1'b1;
      interrupt        = 32'h400;
      step(1);
      chk("pp_cnt",  64'(fifo_cnt),       64'd8);
      chk("pp_head", 64'(evt_if.evt_vec), 64'h2);
      evt_if.evt_ready = 1'b0;
      interrupt        = '0;
      step(1);

      // drain: order preserved, coalesced pend entry last
      evt_if.evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain_%0d", k), 64'(evt_if.evt_vec), 64'(drain_exp[k]));
         step(1);
      end
      chk("drain_cnt", 64'(fifo_cnt), 64'd0);
      chk("drain_ovf", 64'(ovf_cnt),  64'd1);
      evt_if.evt_ready = 1'b0;

      // asynchronous reset with 4 queued entries
      for (int i = 0; i < 4; i++) begin
         interrupt = 32'(1) << i;
         step(1);
      end
      interrupt = '0;
      step(1);
      chk("rq_cnt", 64'(fifo_cnt), 64'd4);
      #2;
      arest_n = 1'b0;
      #1;
      chk("rq_valid", 64'(evt_if.evt_valid), 64'd0);
      chk("rq_cnt0",  64'(fifo_cnt),         64'd0);
      chk("rq_ovf0",  64'(ovf_cnt),          64'd0);

      // input high at reset release reports as an edge; nothing pre-reset
      interrupt = 32'h4;
      step(1);
      arest_n = 1'b1;
      step(1);
      chk("rel_valid",  64'(evt_if.evt_valid), 64'd1);
      chk("rel_vec",    64'(evt_if.evt_vec),   64'h4);
      chk("rel_cnt",    64'(fifo_cnt),         64'd1);
      chk("rel_tstamp", evt_if.evt_tstamp,     64'd0);

      // timestamp: event raised after 5 post-reset edges
      interrupt = '0;
      arest_n   = 1'b0;
      step(1);
      arest_n = 1'b1;
      step(5);
      interrupt = 32'h4;
      step(1);
      chk("ts_vec", 64'(evt_if.evt_vec), 64'h4);
`ifdef EVA_INTR_TSTAMP_EN
      chk("ts_val", evt_if.evt_tstamp, 64'd5);
`else
      chk("ts_val", evt_if.evt_tstamp, 64'd0);
`endif
      interrupt        = '0;
      evt_if.evt_ready = 1'b1;
      step(1);
      evt_if.evt_ready = 1'b0;
      chk("ts_pop_cnt", 64'(fifo_cnt), 64'd0);

      // ovf_clr wins over a same-cycle increment
      for (int i = 0; i < 9; i++) begin
         interrupt = 32'(1) << i;
         step(1);
      end
      interrupt = '0;
      step(1);
      interrupt = 32'h100;
      step(1);
      chk("clr_pre_ovf", 64'(ovf_cnt), 64'd1);
      interrupt = '0;
      step(1);
      interrupt = 32'h100;
      ovf_clr   = 1'b1;
      step(1);
      chk("clr_ovf", 64'(ovf_cnt), 64'd0);
      ovf_clr   = 1'b0;
      interrupt = '0;
      step(1);
      chk("clr_cnt", 64'(fifo_cnt), 64'd8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
